// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module  : hazard_tracker
// Brief   : Load-use stall / bubble control and per-stage destination tracking
//           for a five-stage pipeline with a memory-ready freeze.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_tracker #(
    // Width of the internal stall counter; it saturates at all-ones of this width.
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Aw_DEC,
    input  logic        RegWrite_DEC,
    input  logic        MemRead_DEC,
    input  logic [4:0]  Rn_DEC,
    input  logic [4:0]  Rm_DEC,
    input  logic        RnUsed_DEC,
    input  logic        RmUsed_DEC,
    input  logic        flush,
    input  logic        mem_ready,
    output logic [4:0]  Aw_EXE,
    output logic [4:0]  Aw_MEM,
    output logic [4:0]  Aw_WB,
    output logic        RegWrite_EXE,
    output logic        RegWrite_MEM,
    output logic        RegWrite_WB,
    output logic        MemRead_EXE,
    output logic        stall,
    output logic        bubble,
    output logic [15:0] stall_cycles
);

    localparam logic [4:0]             c_ZERO_REG = 5'd31;
    localparam logic [STALL_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [STALL_CNT_W-1:0] c_CNT_ONE  = STALL_CNT_W'(1);

    logic [4:0]             r_aw_exe;
    logic [4:0]             r_aw_mem;
    logic [4:0]             r_aw_wb;
    logic                   r_rw_exe;
    logic                   r_rw_mem;
    logic                   r_rw_wb;
    logic                   r_mr_exe;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic w_rn_hit;
    logic w_rm_hit;
    logic w_load_use;
    logic w_freeze;

    assign w_rn_hit   = RnUsed_DEC && (Rn_DEC == r_aw_exe);
    assign w_rm_hit   = RmUsed_DEC && (Rm_DEC == r_aw_exe);
    // X31 is the zero register: a load targeting it never produces a value to wait for.
    assign w_load_use = r_mr_exe && r_rw_exe && (r_aw_exe != c_ZERO_REG) && (w_rn_hit || w_rm_hit);
    assign w_freeze   = !mem_ready;

    assign stall  = w_load_use || w_freeze;
    assign bubble = (w_load_use || flush) && !w_freeze;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_exe       <= c_ZERO_REG;
            r_aw_mem       <= c_ZERO_REG;
            r_aw_wb        <= c_ZERO_REG;
            r_rw_exe       <= 1'b0;
            r_rw_mem       <= 1'b0;
            r_rw_wb        <= 1'b0;
            r_mr_exe       <= 1'b0;
            r_stall_cycles <= '0;
        end else if (!w_freeze) begin
            r_aw_wb  <= r_aw_mem;
            r_rw_wb  <= r_rw_mem;
            r_aw_mem <= r_aw_exe;
            r_rw_mem <= r_rw_exe;
            if (bubble) begin
                r_aw_exe <= c_ZERO_REG;
                r_rw_exe <= 1'b0;
                r_mr_exe <= 1'b0;
            end else begin
                r_aw_exe <= Aw_DEC;
                r_rw_exe <= RegWrite_DEC;
                r_mr_exe <= MemRead_DEC;
            end
            if (w_load_use && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            end
        end
    end

    assign Aw_EXE       = r_aw_exe;
    assign Aw_MEM       = r_aw_mem;
    assign Aw_WB        = r_aw_wb;
    assign RegWrite_EXE = r_rw_exe;
    assign RegWrite_MEM = r_rw_mem;
    assign RegWrite_WB  = r_rw_wb;
    assign MemRead_EXE  = r_mr_exe;
    assign stall_cycles = 16'(r_stall_cycles);

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_tracker
// Brief   : Self-checking bench: directed vector table, hand-written corner
//           sequences and randomized traffic against a pipeline-list model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Aw_DEC, Rn_DEC, Rm_DEC;
    logic        RegWrite_DEC, MemRead_DEC, RnUsed_DEC, RmUsed_DEC, flush, mem_ready;
    logic [4:0]  Aw_EXE, Aw_MEM, Aw_WB;
    logic        RegWrite_EXE, RegWrite_MEM, RegWrite_WB, MemRead_EXE, stall, bubble;
    logic [15:0] stall_cycles;
    // narrow-counter twin, sharing all inputs, so saturation is reachable quickly
    logic [4:0]  s_aw_exe, s_aw_mem, s_aw_wb;
    logic        s_rw_exe, s_rw_mem, s_rw_wb, s_mr_exe, s_stall, s_bubble;
    logic [15:0] s_cycles;

    hazard_tracker u_dut (
        .clk(clk), .reset(reset), .Aw_DEC(Aw_DEC), .RegWrite_DEC(RegWrite_DEC),
        .MemRead_DEC(MemRead_DEC), .Rn_DEC(Rn_DEC), .Rm_DEC(Rm_DEC),
        .RnUsed_DEC(RnUsed_DEC), .RmUsed_DEC(RmUsed_DEC), .flush(flush),
        .mem_ready(mem_ready), .Aw_EXE(Aw_EXE), .Aw_MEM(Aw_MEM), .Aw_WB(Aw_WB),
        .RegWrite_EXE(RegWrite_EXE), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .MemRead_EXE(MemRead_EXE), .stall(stall), .bubble(bubble), .stall_cycles(stall_cycles)
    );

    hazard_tracker #(.STALL_CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .Aw_DEC(Aw_DEC), .RegWrite_DEC(RegWrite_DEC),
        .MemRead_DEC(MemRead_DEC), .Rn_DEC(Rn_DEC), .Rm_DEC(Rm_DEC),
        .RnUsed_DEC(RnUsed_DEC), .RmUsed_DEC(RmUsed_DEC), .flush(flush),
        .mem_ready(mem_ready), .Aw_EXE(s_aw_exe), .Aw_MEM(s_aw_mem), .Aw_WB(s_aw_wb),
        .RegWrite_EXE(s_rw_exe), .RegWrite_MEM(s_rw_mem), .RegWrite_WB(s_rw_wb),
        .MemRead_EXE(s_mr_exe), .stall(s_stall), .bubble(s_bubble), .stall_cycles(s_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_stall, last_bubble;

    // model: list of in-flight instructions, index 0 = EXE, 1 = MEM, 2 = WB
    typedef struct { logic [4:0] aw; logic rw; logic mr; } instr_t;
    instr_t      m_pipe[3];
    int unsigned m_stalls;

    typedef struct {
        logic [4:0] aw; logic rw; logic mr; logic [4:0] rn; logic [4:0] rm;
        logic rnu; logic rmu; logic fl; logic rdy;
        logic e_stall; logic e_bubble; logic [4:0] e_exe; logic [4:0] e_mem; logic [4:0] e_wb;
        logic e_rw_exe; logic [15:0] e_cnt;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_load_use();
        instr_t e = m_pipe[0];
        if (!(e.mr && e.rw) || e.aw == 5'd31) return 1'b0;
        return (RnUsed_DEC && Rn_DEC == e.aw) || (RmUsed_DEC && Rm_DEC == e.aw);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '{aw: 5'd31, rw: 1'b0, mr: 1'b0};
        m_stalls = 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, " Aw_EXE"}, 32'(Aw_EXE), 32'(m_pipe[0].aw));
        check({tag, " Aw_MEM"}, 32'(Aw_MEM), 32'(m_pipe[1].aw));
        check({tag, " Aw_WB"}, 32'(Aw_WB), 32'(m_pipe[2].aw));
        check({tag, " RegWrite_EXE"}, 32'(RegWrite_EXE), 32'(m_pipe[0].rw));
        check({tag, " RegWrite_MEM"}, 32'(RegWrite_MEM), 32'(m_pipe[1].rw));
        check({tag, " RegWrite_WB"}, 32'(RegWrite_WB), 32'(m_pipe[2].rw));
        check({tag, " MemRead_EXE"}, 32'(MemRead_EXE), 32'(m_pipe[0].mr));
        check({tag, " stall_cycles"}, 32'(stall_cycles), (m_stalls > 65535) ? 32'd65535 : m_stalls);
        check({tag, " sat stall_cycles"}, 32'(s_cycles), (m_stalls > 15) ? 32'd15 : m_stalls);
    endtask

    // One clock: check combinational outputs, take the edge, advance model, check state.
    task automatic step(input string tag);
        logic lu;
        #1;
        lu = m_load_use();
        last_stall  = stall;
        last_bubble = bubble;
        check({tag, " stall"}, 32'(stall), 32'(lu || !mem_ready));
        check({tag, " bubble"}, 32'(bubble), 32'((lu || flush) && mem_ready));
        @(posedge clk);
        if (mem_ready) begin
            if (lu) m_stalls++;
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            if (lu || flush) m_pipe[0] = '{aw: 5'd31, rw: 1'b0, mr: 1'b0};
            else             m_pipe[0] = '{aw: Aw_DEC, rw: RegWrite_DEC, mr: MemRead_DEC};
        end
        #1;
        check_model(tag);
    endtask

    task automatic set_dec(input logic [4:0] aw, input logic rw, input logic mr,
                           input logic [4:0] rn, input logic [4:0] rm, input logic rnu,
                           input logic rmu, input logic fl, input logic rdy);
        Aw_DEC = aw; RegWrite_DEC = rw; MemRead_DEC = mr; Rn_DEC = rn; Rm_DEC = rm;
        RnUsed_DEC = rnu; RmUsed_DEC = rmu; flush = fl; mem_ready = rdy;
    endtask

    task automatic check_stages(input string tag, input logic [4:0] exe, input logic [4:0] mem,
                                input logic [4:0] wb, input logic [15:0] cnt);
        check({tag, " Aw_EXE"}, 32'(Aw_EXE), 32'(exe));
        check({tag, " Aw_MEM"}, 32'(Aw_MEM), 32'(mem));
        check({tag, " Aw_WB"}, 32'(Aw_WB), 32'(wb));
        check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(cnt));
    endtask

    function automatic logic [4:0] rand_reg();
        int r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          aw    rw    mr    rn     rm     rnu   rmu   fl    rdy   st    bu    exe    mem    wb     rwe   cnt
        vecs[0]  = '{5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd31, 5'd31, 1'b1, 16'd0};
        vecs[1]  = '{5'd7, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 5'd3, 5'd31, 1'b0, 16'd1};
        vecs[2]  = '{5'd7, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd31, 5'd3, 1'b1, 16'd1};
        vecs[3]  = '{5'd31, 1'b1, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 5'd7, 5'd31, 1'b1, 16'd1};
        vecs[4]  = '{5'd5, 1'b1, 1'b0, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd31, 5'd7, 1'b1, 16'd1};
        vecs[5]  = '{5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd5, 5'd31, 1'b1, 16'd1};
        vecs[6]  = '{5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd6, 5'd5, 1'b1, 16'd1};
        vecs[7]  = '{5'd2, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd1, 5'd6, 1'b1, 16'd1};
        vecs[8]  = '{5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd2, 5'd1, 1'b1, 16'd1};
        vecs[9]  = '{5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 5'd3, 5'd2, 1'b1, 16'd1};
        vecs[10] = '{5'd10, 1'b1, 1'b0, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 5'd8, 5'd3, 1'b0, 16'd2};
        vecs[11] = '{5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 5'd31, 5'd8, 1'b0, 16'd2};
        vecs[12] = '{5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd31, 5'd31, 1'b1, 16'd2};
        vecs[13] = '{5'd13, 1'b1, 1'b0, 5'd12, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13, 5'd12, 5'd31, 1'b1, 16'd2};
        vecs[14] = '{5'd14, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14, 5'd13, 5'd12, 1'b0, 16'd2};
        vecs[15] = '{5'd15, 1'b1, 1'b0, 5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15, 5'd14, 5'd13, 1'b1, 16'd2};

        // reset state, and stall/bubble following only mem_ready/flush while in reset
        reset = 1'b1;
        set_dec(5'd0, 1'b0, 1'b0, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        m_reset();
        check_model("reset");
        check("reset stall", 32'(stall), 32'd0);
        check("reset bubble", 32'(bubble), 32'd0);
        mem_ready = 1'b0; flush = 1'b1;
        #1;
        check("reset freeze stall", 32'(stall), 32'd1);
        check("reset freeze bubble", 32'(bubble), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("reset flush stall", 32'(stall), 32'd0);
        check("reset flush bubble", 32'(bubble), 32'd1);
        flush = 1'b0;
        #1;
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 16; i++) begin
            set_dec(vecs[i].aw, vecs[i].rw, vecs[i].mr, vecs[i].rn, vecs[i].rm,
                    vecs[i].rnu, vecs[i].rmu, vecs[i].fl, vecs[i].rdy);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl stall", i), 32'(last_stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d tbl bubble", i), 32'(last_bubble), 32'(vecs[i].e_bubble));
            check_stages($sformatf("vec%0d tbl", i), vecs[i].e_exe, vecs[i].e_mem, vecs[i].e_wb, vecs[i].e_cnt);
            check($sformatf("vec%0d tbl RegWrite_EXE", i), 32'(RegWrite_EXE), 32'(vecs[i].e_rw_exe));
        end

        // freeze for three cycles with a load-use pending, flush asserted on one of them
        set_dec(5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("frz load");
        check_stages("frz load", 5'd4, 5'd15, 5'd14, 16'd2);
        for (int i = 0; i < 3; i++) begin
            set_dec(5'd20, 1'b1, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, (i == 1), 1'b0);
            step("frz hold");
            check("frz stall", 32'(last_stall), 32'd1);
            check("frz bubble", 32'(last_bubble), 32'd0);
            check_stages("frz hold", 5'd4, 5'd15, 5'd14, 16'd2);
        end
        mem_ready = 1'b1; flush = 1'b0;
        step("frz release");
        check("frz release bubble", 32'(last_bubble), 32'd1);
        check_stages("frz release", 5'd31, 5'd4, 5'd15, 16'd3);
        step("frz after");
        check("frz after stall", 32'(last_stall), 32'd0);
        check_stages("frz after", 5'd20, 5'd31, 5'd4, 16'd3);

        // repeated load-use, one every two cycles, drives the narrow counter into saturation
        set_dec(5'd3, 1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step("sat");
        check("sat narrow counter", 32'(s_cycles), 32'd15);
        check("sat wide counter", 32'(stall_cycles), 32'd23);

        // reset pulsed between edges with the pipe full and a frozen load-use pending
        set_dec(5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rst fill1");
        set_dec(5'd10, 1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rst fill2");
        #2;
        reset = 1'b1;
        #1;
        check_stages("async rst", 5'd31, 5'd31, 5'd31, 16'd0);
        check("async rst RegWrite_EXE", 32'(RegWrite_EXE), 32'd0);
        check("async rst RegWrite_WB", 32'(RegWrite_WB), 32'd0);
        check("async rst MemRead_EXE", 32'(MemRead_EXE), 32'd0);
        check("async rst sat counter", 32'(s_cycles), 32'd0);
        check("async rst stall", 32'(stall), 32'd1);
        check("async rst bubble", 32'(bubble), 32'd0);
        m_reset();
        #2;
        reset = 1'b0;
        mem_ready = 1'b1;
        step("post rst");
        check("post rst bubble", 32'(last_bubble), 32'd0);
        check_stages("post rst", 5'd10, 5'd31, 5'd31, 16'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_dec(rand_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rand_reg(), rand_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
